// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed 4-digit BCD seven-segment driver
// with leading-zero blanking and a sticky non-BCD load flag.
module seg7_scan_display #(
    parameter int SCAN_DIV = 25000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load,
    input  logic [15:0] Din,
    input  logic        Blank_lz,
    output logic [3:0]  Sel,
    output logic [6:0]  Seg,
    output logic        Err
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [15:0]   r_shadow;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_sel;
    logic [6:0]    r_seg;
    logic          r_err;

    logic          w_adv;
    logic [1:0]    w_nidx;
    logic [3:0]    w_nib;
    logic [3:0]    w_lz;
    logic          w_blank;
    logic          w_bad;
    logic [6:0]    w_dec;
    logic [6:0]    w_seg;

    assign w_adv  = r_cnt == CW'(SCAN_DIV - 1);
    assign w_nidx = r_idx + 2'd1;
    assign w_nib  = r_shadow[4*w_nidx +: 4];

    // w_lz[i]: digit i and every higher digit of the shadow are zero
    assign w_lz[3] = r_shadow[15:12] == 4'd0;
    assign w_lz[2] = w_lz[3] && r_shadow[11:8] == 4'd0;
    assign w_lz[1] = w_lz[2] && r_shadow[7:4] == 4'd0;
    assign w_lz[0] = 1'b0;

    assign w_blank = Blank_lz && w_lz[w_nidx];
    assign w_bad   = Din[15:12] > 4'd9 || Din[11:8] > 4'd9 ||
                     Din[7:4] > 4'd9 || Din[3:0] > 4'd9;

    always_comb begin
        w_dec = 7'h3F;
        case (w_nib)
            4'd0: w_dec = 7'h40;
            4'd1: w_dec = 7'h79;
            4'd2: w_dec = 7'h24;
            4'd3: w_dec = 7'h30;
            4'd4: w_dec = 7'h19;
            4'd5: w_dec = 7'h12;
            4'd6: w_dec = 7'h02;
            4'd7: w_dec = 7'h78;
            4'd8: w_dec = 7'h00;
            4'd9: w_dec = 7'h10;
            default: w_dec = 7'h3F;
        endcase
    end

    assign w_seg = w_blank ? 7'h7F : w_dec;

    // Outputs are refreshed only on the advance edge, from the pre-edge shadow
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_shadow <= 16'h0000;
            r_cnt    <= '0;
            r_idx    <= 2'd3;
            r_sel    <= 4'b1111;
            r_seg    <= 7'h7F;
            r_err    <= 1'b0;
        end else begin
            if (Load) r_shadow <= Din;
            if (Load && w_bad) r_err <= 1'b1;
            r_cnt <= w_adv ? '0 : r_cnt + CW'(1);
            if (w_adv) begin
                r_idx <= w_nidx;
                r_sel <= ~(4'b0001 << w_nidx);
                r_seg <= w_seg;
            end
        end
    end

    assign Sel = r_sel;
    assign Seg = r_seg;
    assign Err = r_err;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed bench for seg7_scan_display with SCAN_DIV=4;
// inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_scan_display;
    localparam logic [3:0] S0 = 4'b1110;
    localparam logic [3:0] S1 = 4'b1101;
    localparam logic [3:0] S2 = 4'b1011;
    localparam logic [3:0] S3 = 4'b0111;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Load = 1'b0;
    logic [15:0] Din = 16'h0000;
    logic        Blank_lz = 1'b0;
    logic [3:0]  Sel;
    logic [6:0]  Seg;
    logic        Err;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] v;

    seg7_scan_display #(.SCAN_DIV(4)) dut (
        .Clk(Clk), .Rst(Rst), .Load(Load), .Din(Din), .Blank_lz(Blank_lz),
        .Sel(Sel), .Seg(Seg), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full digit period starting just after an advance; optional Load on its first edge
    task automatic step(input string tag, input bit ld, input logic [15:0] din,
                        input logic [3:0] s, input logic [6:0] g);
        if (ld) begin
            Load = 1'b1;
            Din  = din;
        end
        @(negedge Clk);
        Load = 1'b0;
        repeat (3) @(negedge Clk);
        check({tag, "_sel"}, 16'(Sel), 16'(s));
        check({tag, "_seg"}, 16'(Seg), 16'(g));
    endtask

    function automatic logic [6:0] segx(input logic [15:0] val, input int i, input logic bl);
        logic [3:0] n;
        n = val[4*i +: 4];
        if (bl && i > 0 && (val >> (4*i)) == 16'h0) return 7'h7F;
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] val);
        logic c;
        c = 1'b1;
        for (int i = 0; i < 4; i++)
            if (c) begin
                if (val[4*i +: 4] == 4'd9) val[4*i +: 4] = 4'd0;
                else begin
                    val[4*i +: 4] = val[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        return val;
    endfunction

    initial begin
        repeat (10) @(negedge Clk);
        check("rst_sel", 16'(Sel), 16'hF);
        check("rst_seg", 16'(Seg), 16'h7F);
        check("rst_err", 16'(Err), 16'h0);
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("s1_hold_sel", 16'(Sel), 16'hF);
            check("s1_hold_seg", 16'(Seg), 16'h7F);
        end
        @(negedge Clk);
        check("s1_first_sel", 16'(Sel), 16'(S0));
        check("s1_first_seg", 16'(Seg), 16'h40);

        step("s2_d1", 1, 16'h1234, S1, 7'h30);
        step("s2_d2", 0, 16'h0, S2, 7'h24);
        step("s2_d3", 0, 16'h0, S3, 7'h79);
        step("s2_d0", 0, 16'h0, S0, 7'h19);
        step("s2_d1b", 0, 16'h0, S1, 7'h30);
        step("s2_d2b", 0, 16'h0, S2, 7'h24);
        step("s2_d3b", 0, 16'h0, S3, 7'h79);
        step("s2_d0b", 0, 16'h0, S0, 7'h19);

        Blank_lz = 1'b1;
        step("s3_d1", 1, 16'h0070, S1, 7'h78);
        step("s3_d2", 0, 16'h0, S2, 7'h7F);
        step("s3_d3", 0, 16'h0, S3, 7'h7F);
        step("s3_d0", 0, 16'h0, S0, 7'h40);
        Load = 1'b1;
        Din  = 16'h1111;
        @(negedge Clk);
        Din  = 16'h0000;
        @(negedge Clk);
        Load = 1'b0;
        repeat (2) @(negedge Clk);
        check("s3_b2b_sel", 16'(Sel), 16'(S1));
        check("s3_b2b_seg", 16'(Seg), 16'h7F);
        step("s3_z2", 0, 16'h0, S2, 7'h7F);
        step("s3_z3", 0, 16'h0, S3, 7'h7F);
        step("s3_z0", 0, 16'h0, S0, 7'h40);
        check("s3_err", 16'(Err), 16'h0);

        Load = 1'b1;
        Din  = 16'h00A5;
        @(negedge Clk);
        Load = 1'b0;
        check("s4_err_set", 16'(Err), 16'h1);
        repeat (3) @(negedge Clk);
        check("s4_dash_sel", 16'(Sel), 16'(S1));
        check("s4_dash_seg", 16'(Seg), 16'h3F);
        step("s4_d2", 0, 16'h0, S2, 7'h7F);
        step("s4_d3", 0, 16'h0, S3, 7'h7F);
        step("s4_d0", 0, 16'h0, S0, 7'h12);
        step("s4_reload", 1, 16'h0005, S1, 7'h7F);
        check("s4_err_hold", 16'(Err), 16'h1);
        repeat (3) @(negedge Clk);
        Rst  = 1'b1;
        Load = 1'b1;
        Din  = 16'h9999;
        @(negedge Clk);
        check("s4_rst_sel", 16'(Sel), 16'hF);
        check("s4_rst_seg", 16'(Seg), 16'h7F);
        check("s4_rst_err", 16'(Err), 16'h0);
        Rst  = 1'b0;
        Load = 1'b0;
        repeat (3) @(negedge Clk);
        check("s4_rel_hold", 16'(Sel), 16'hF);
        @(negedge Clk);
        check("s4_rel_sel", 16'(Sel), 16'(S0));
        check("s4_rel_seg", 16'(Seg), 16'h40);

        Blank_lz = 1'b0;
        step("nb_d1", 0, 16'h0, S1, 7'h40);
        step("nb_d2", 0, 16'h0, S2, 7'h40);
        step("nb_d3", 0, 16'h0, S3, 7'h40);
        step("nb_d0", 0, 16'h0, S0, 7'h40);

        step("s5_d1", 1, 16'h0003, S1, 7'h40);
        step("s5_d2", 0, 16'h0, S2, 7'h40);
        step("s5_d3", 0, 16'h0, S3, 7'h40);
        repeat (3) @(negedge Clk);
        Load = 1'b1;
        Din  = 16'h0009;
        @(negedge Clk);
        Load = 1'b0;
        check("s5_old_sel", 16'(Sel), 16'(S0));
        check("s5_old_seg", 16'(Seg), 16'h30);
        step("s5_n1", 0, 16'h0, S1, 7'h40);
        step("s5_n2", 0, 16'h0, S2, 7'h40);
        step("s5_n3", 0, 16'h0, S3, 7'h40);
        step("s5_new", 0, 16'h0, S0, 7'h10);

        Blank_lz = 1'b1;
        v = 16'h0088;
        for (int k = 0; k < 30; k++) begin
            v = bcd_inc(v);
            step($sformatf("s6_%0h_d1", v), 1, v, S1, segx(v, 1, 1'b1));
            step($sformatf("s6_%0h_d2", v), 0, 16'h0, S2, segx(v, 2, 1'b1));
            step($sformatf("s6_%0h_d3", v), 0, 16'h0, S3, segx(v, 3, 1'b1));
            step($sformatf("s6_%0h_d0", v), 0, 16'h0, S0, segx(v, 0, 1'b1));
        end
        check("s6_err", 16'(Err), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
